// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: state encoding, stat width
// and the round-robin search function used by rr_pick.
package fifo_arb_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 16;
  localparam int MAX_IDW = 4;

  // First valid index after last (wrapping mod n); last itself is checked last.
  // If nothing is valid, last is returned unchanged.
  function automatic logic [MAX_IDW-1:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                                 input logic [MAX_IDW-1:0] last,
                                                 input int n);
    logic [MAX_IDW-1:0] res;
    int j;
    res = last;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        j = (int'(last) + k) % n;
        if (valid[j]) res = MAX_IDW'(j);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: next valid requester after the last owner.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IDW-1:0]  last,
  output logic [IDW-1:0]  idx,
  output logic            any
);

  logic [MAX_IDW-1:0] pick_full;

  assign pick_full = rr_next(MAX_REQ'(valid), MAX_IDW'(last), NREQ);
  assign idx       = IDW'(pick_full);
  assign any       = |valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ requesters.
// Optional per-requester word and stall counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int  NREQ   = 4,
  parameter int  DWIDTH = 16,
  parameter int  BURST  = 8,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                     wclk,
  input  logic                     srst_n,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DWIDTH-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     wdv,
  output logic [DWIDTH-1:0]        wdata,
  input  logic                     wfull,
  output logic                     busy,
  output logic [IDW-1:0]           owner
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [NREQ*STAT_W-1:0]   stat_words,
  output logic [STAT_W-1:0]        stat_stall
`endif
);

  localparam int BCW = $clog2(BURST + 1);

  logic           state;
  logic [BCW-1:0] bcnt;
  logic           grant;
  logic           own_vld;
  logic           xfer;
  logic           last_beat;
  logic [IDW-1:0] pick;
  logic           any_vld;

  rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
    .valid (req_valid),
    .last  (owner),
    .idx   (pick),
    .any   (any_vld)
  );

  // Zero-latency datapath; reset gates everything so an in-flight word is never written.
  always_comb begin
    grant     = srst_n && (state == ST_GRANT);
    own_vld   = 1'b0;
    wdata     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) begin
        own_vld = req_valid[i];
        if (grant) wdata = req_data[i*DWIDTH +: DWIDTH];
      end
    end
    xfer      = grant && own_vld && !wfull;
    wdv       = xfer;
    busy      = grant;
    last_beat = (bcnt == BCW'(BURST - 1));
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IDW'(i)) req_ready[i] = xfer;
    end
  end

  always_ff @(posedge wclk) begin
    if (!srst_n) begin
      state <= ST_IDLE;
      owner <= IDW'(NREQ - 1);
      bcnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_vld) begin
            state <= ST_GRANT;
            owner <= pick;
            bcnt  <= '0;
          end
        end
        default: begin
          // Handover re-picks from this cycle's valids, so a lone requester is re-granted.
          if ((xfer && last_beat) || !own_vld) begin
            bcnt <= '0;
            if (any_vld) owner <= pick;
            else         state <= ST_IDLE;
          end else if (xfer) begin
            bcnt <= bcnt + 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [STAT_W-1:0] words_q [NREQ];
  logic [STAT_W-1:0] stall_q;

  always_ff @(posedge wclk) begin
    if (!srst_n || stat_clr) begin
      for (int i = 0; i < NREQ; i++) words_q[i] <= '0;
      stall_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_ready[i]) words_q[i] <= sat_inc(words_q[i]);
      end
      if (grant && own_vld && wfull) stall_q <= sat_inc(stall_q);
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) stat_words[i*STAT_W +: STAT_W] = words_q[i];
    stat_stall = stall_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DWIDTH=16, BURST=8).
module tb_fifo_wr_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic              wclk = 1'b0;
  logic              srst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              wdv;
  logic [DW-1:0]     wdata;
  logic              wfull;
  logic              busy;
  logic [1:0]        owner;
`ifdef FIFO_WR_ARB_STATS_EN
  logic              stat_clr;
  logic [NREQ*16-1:0] stat_words;
  logic [15:0]       stat_stall;
`endif

  int checks   = 0;
  int failures = 0;

  logic [15:0] base [NREQ];
  int          cnt  [NREQ];
  logic [NREQ-1:0] rdy_s;

  fifo_wr_arbiter #(.NREQ(NREQ), .DWIDTH(DW), .BURST(8)) dut (
    .wclk      (wclk),
    .srst_n    (srst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wdv       (wdv),
    .wdata     (wdata),
    .wfull     (wfull),
    .busy      (busy),
    .owner     (owner)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_words(stat_words),
    .stat_stall(stat_stall)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic update_data();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = base[i] + 16'(cnt[i]);
  endtask

  // Advance one clock; requesters whose word was accepted present their next word.
  task automatic step();
    rdy_s = req_ready;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NREQ; i++) if (rdy_s[i]) cnt[i]++;
    update_data();
  endtask

  task automatic do_reset();
    srst_n    = 1'b0;
    req_valid = '0;
    wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i]  = 0;
      base[i] = '0;
    end
    update_data();
    @(posedge wclk);
    #1;
    srst_n = 1'b1;
  endtask

  task automatic test_reset();
    srst_n    = 1'b0;
    req_valid = '0;
    wfull     = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cnt[i]  = 0;
      base[i] = 16'hAAAA;
    end
    update_data();
    for (int c = 0; c < 2; c++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b0 || busy !== 1'b0 || req_ready !== 4'b0 || wdata !== 16'h0) begin
        failures++;
        $display("FAIL reset_outputs: wdv=%b busy=%b ready=%b wdata=%h, required 0 0 0000 0000",
                 wdv, busy, req_ready, wdata);
      end
      step();
    end
    srst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b0 || busy !== 1'b0 || owner !== 2'd3) begin
        failures++;
        $display("FAIL idle_after_reset c=%0d: wdv=%b busy=%b owner=%0d, required 0 0 3",
                 c, wdv, busy, owner);
      end
      step();
    end
  endtask

  task automatic test_single_requester();
    do_reset();
    base[2] = 16'h2000;
    update_data();
    req_valid = 4'b0100;
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL single_bubble: wdv=%b busy=%b, required 0 0", wdv, busy);
    end
    step();
    for (int k = 0; k < 20; k++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b1 || req_ready !== 4'b0100 || owner !== 2'd2 || wdata !== 16'h2000 + 16'(k)) begin
        failures++;
        $display("FAIL single_stream k=%0d: wdv=%b ready=%b owner=%0d wdata=%h, required 1 0100 2 %h",
                 k, wdv, req_ready, owner, wdata, 16'h2000 + 16'(k));
      end
      step();
      if (k == 19) req_valid = '0;
    end
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_release: wdv=%b busy=%b, required 0 1", wdv, busy);
    end
    step();
    @(negedge wclk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL single_idle: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_fairness();
    int o;
    int n;
    do_reset();
    for (int i = 0; i < NREQ; i++) base[i] = 16'h0300 + 16'(i << 12);
    update_data();
    req_valid = 4'b1111;
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b0) begin
      failures++;
      $display("FAIL fair_bubble: wdv=%b, required 0", wdv);
    end
    step();
    for (int c = 0; c < 40; c++) begin
      o = (c / 8) % 4;
      n = (c / 32) * 8 + (c % 8);
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b1 || owner !== 2'(o) || req_ready !== 4'(1 << o) || wdata !== base[o] + 16'(n)) begin
        failures++;
        $display("FAIL fair_rr c=%0d: wdv=%b owner=%0d ready=%b wdata=%h, required 1 %0d %b %h",
                 c, wdv, owner, req_ready, wdata, o, 4'(1 << o), base[o] + 16'(n));
      end
      step();
    end
    req_valid = '0;
  endtask

  task automatic test_full();
    do_reset();
    base[1] = 16'h4100;
    update_data();
    req_valid = 4'b0010;
    @(negedge wclk);
    step();
    for (int k = 0; k < 32; k++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b1 || wdata !== 16'h4100 + 16'(k)) begin
        failures++;
        $display("FAIL full_fill k=%0d: wdv=%b wdata=%h, required 1 %h", k, wdv, wdata, 16'h4100 + 16'(k));
      end
      step();
    end
    wfull = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b1 || owner !== 2'd1) begin
        failures++;
        $display("FAIL full_hold c=%0d: wdv=%b ready=%b busy=%b owner=%0d, required 0 0000 1 1",
                 c, wdv, req_ready, busy, owner);
      end
      step();
    end
    wfull = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b1 || owner !== 2'd1 || wdata !== 16'h4120 + 16'(k)) begin
        failures++;
        $display("FAIL full_resume k=%0d: wdv=%b owner=%0d wdata=%h, required 1 1 %h",
                 k, wdv, owner, wdata, 16'h4120 + 16'(k));
      end
      step();
      if (k == 7) req_valid = '0;
    end
`ifdef FIFO_WR_ARB_STATS_EN
    checks++;
    if (stat_words[16 +: 16] !== 16'd40 || stat_stall !== 16'd5) begin
      failures++;
      $display("FAIL full_stats: words1=%0d stall=%0d, required 40 5", stat_words[16 +: 16], stat_stall);
    end
`endif
  endtask

  task automatic test_early_release();
    do_reset();
    base[0] = 16'h5000;
    base[3] = 16'h5300;
    update_data();
    req_valid = 4'b1001;
    @(negedge wclk);
    step();
    for (int k = 0; k < 3; k++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b1 || owner !== 2'd0 || wdata !== 16'h5000 + 16'(k)) begin
        failures++;
        $display("FAIL early_first k=%0d: wdv=%b owner=%0d wdata=%h, required 1 0 %h",
                 k, wdv, owner, wdata, 16'h5000 + 16'(k));
      end
      step();
    end
    req_valid = 4'b1000;
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b0 || owner !== 2'd0) begin
      failures++;
      $display("FAIL early_drop: wdv=%b owner=%0d, required 0 0", wdv, owner);
    end
    step();
    req_valid = 4'b1001;
    for (int c = 0; c < 16; c++) begin
      @(negedge wclk);
      checks++;
      if (c < 8) begin
        if (wdv !== 1'b1 || owner !== 2'd3 || wdata !== 16'h5300 + 16'(c)) begin
          failures++;
          $display("FAIL early_req3 c=%0d: wdv=%b owner=%0d wdata=%h, required 1 3 %h",
                   c, wdv, owner, wdata, 16'h5300 + 16'(c));
        end
      end else begin
        if (wdv !== 1'b1 || owner !== 2'd0 || wdata !== 16'h5003 + 16'(c - 8)) begin
          failures++;
          $display("FAIL early_req0_burst c=%0d: wdv=%b owner=%0d wdata=%h, required 1 0 %h",
                   c, wdv, owner, wdata, 16'h5003 + 16'(c - 8));
        end
      end
      step();
    end
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b1 || owner !== 2'd3 || wdata !== 16'h5308) begin
      failures++;
      $display("FAIL early_back_to_3: wdv=%b owner=%0d wdata=%h, required 1 3 5308", wdv, owner, wdata);
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_mid_burst_reset();
    do_reset();
    base[0] = 16'h0A00;
    base[2] = 16'h2000;
    update_data();
    req_valid = 4'b0100;
    @(negedge wclk);
    step();
    for (int k = 0; k < 4; k++) begin
      @(negedge wclk);
      step();
    end
    checks++;
    if (cnt[2] !== 4) begin
      failures++;
      $display("FAIL mrst_preamble: accepted=%0d, required 4", cnt[2]);
    end
    srst_n    = 1'b0;
    req_valid = 4'b0101;
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b0 || req_ready !== 4'b0 || busy !== 1'b0 || wdata !== 16'h0) begin
      failures++;
      $display("FAIL mrst_gate: wdv=%b ready=%b busy=%b wdata=%h, required 0 0000 0 0000",
               wdv, req_ready, busy, wdata);
    end
    step();
    srst_n = 1'b1;
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b0 || busy !== 1'b0 || owner !== 2'd3) begin
      failures++;
      $display("FAIL mrst_after: wdv=%b busy=%b owner=%0d, required 0 0 3", wdv, busy, owner);
    end
`ifdef FIFO_WR_ARB_STATS_EN
    checks++;
    if (stat_words !== '0 || stat_stall !== 16'd0) begin
      failures++;
      $display("FAIL mrst_stats: words=%h stall=%0d, required 0 0", stat_words, stat_stall);
    end
`endif
    step();
    for (int k = 0; k < 2; k++) begin
      @(negedge wclk);
      checks++;
      if (wdv !== 1'b1 || owner !== 2'd0 || wdata !== 16'h0A00 + 16'(k)) begin
        failures++;
        $display("FAIL mrst_req0 k=%0d: wdv=%b owner=%0d wdata=%h, required 1 0 %h",
                 k, wdv, owner, wdata, 16'h0A00 + 16'(k));
      end
      step();
    end
    req_valid = 4'b0100;
    @(negedge wclk);
    step();
    @(negedge wclk);
    checks++;
    if (wdv !== 1'b1 || owner !== 2'd2 || wdata !== 16'h2004) begin
      failures++;
      $display("FAIL mrst_inflight: wdv=%b owner=%0d wdata=%h, required 1 2 2004", wdv, owner, wdata);
    end
    step();
    req_valid = '0;
  endtask

  initial begin
    srst_n    = 1'b0;
    req_valid = '0;
    req_data  = '0;
    wfull     = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    test_reset();
    test_single_requester();
    test_fairness();
    test_full();
    test_early_release();
    test_mid_burst_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
